// File: rtl/uart_pkg.sv
// uart_pkg: drain FSM state encoding and default sizing shared by the UART TX FIFO.
package uart_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_LOW_WATER = 2;
endpackage

// File: rtl/fifo_mem_1r1w.sv
// fifo_mem_1r1w: DEPTH x 8 storage, synchronous write, asynchronous read.
module fifo_mem_1r1w #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO drained into a UART data register via an IDLE/SEND FSM.
// Low-water interrupt is built only when UART_TXFIFO_IRQ_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int LOW_WATER = DEFAULT_LOW_WATER
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_valid,
  input  logic [7:0]               wr_data,
  output logic                     wr_ready,
  input  logic                     flush,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     irq_low,
  output logic                     uart_dat_we,
  output logic [31:0]              uart_dat_di,
  input  logic                     uart_dat_wait
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  if (DEPTH < 4 || DEPTH > 256 || (1 << AW) != DEPTH || LOW_WATER < 0 || LOW_WATER >= DEPTH) begin : g_bad_cfg
    $error("uart_tx_fifo: unsupported DEPTH/LOW_WATER");
  end
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    out_byte_q, out_byte_d, rd_data;
  logic          overflow_q, overflow_d;
  logic          send, accept, push, pop;
  assign empty = level_q == '0;
  assign full = level_q == LW'(DEPTH);
  assign wr_ready = ~full;
  assign level = level_q;
  assign overflow = overflow_q;
  assign uart_dat_we = send;
  assign uart_dat_di = {24'h0, out_byte_q};
  // push is qualified by full before any same-cycle pop frees a slot
  always_comb begin
    send = state_q == SEND;
    accept = send & ~uart_dat_wait;
    push = wr_valid & ~full & ~flush;
    pop = ~flush & ~empty & (~send | accept);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    state_d = flush ? IDLE : pop ? SEND : accept ? IDLE : state_q;
    out_byte_d = pop ? rd_data : out_byte_q;
    overflow_d = ~clr_overflow & (overflow_q | (wr_valid & full & ~flush));
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      out_byte_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      out_byte_q <= out_byte_d;
      overflow_q <= overflow_d;
    end
  end
  fifo_mem_1r1w #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(push), .waddr(wr_ptr_q), .wdata(wr_data), .raddr(rd_ptr_q), .rdata(rd_data)
  );
`ifdef UART_TXFIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (!resetn) irq_q <= 1'b0;
    else irq_q <= (flush | push) ? 1'b0 : (level_q == LW'(LOW_WATER + 1) && level_d == LW'(LOW_WATER)) ? 1'b1 : irq_q;
  end
  assign irq_low = irq_q;
`else
  assign irq_low = 1'b0;
`endif
endmodule
